// File: rtl/otter_csr_int.sv
// Machine-mode CSR file (mstatus/mtvec/mepc/mcause) and external interrupt front end
// for the OTTER control unit: synchronises, edge-detects and masks the interrupt line.
module otter_csr_int #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [31:0] MTVEC_RST   = 32'h0000_0000,
    parameter logic [31:0] MCAUSE_EXT  = 32'h8000_000B
) (
    input  logic        CSR_CLK,
    input  logic        CSR_RESET_N,
    input  logic        CSR_INT_IN,
    input  logic        CSR_INT_TAKEN,
    input  logic        CSR_INT_CLR,
    input  logic        CSR_WRITE,
    input  logic        CSR_MRET,
    input  logic [2:0]  CSR_FUNC3,
    input  logic [11:0] CSR_ADDR,
    input  logic [31:0] CSR_WD,
    input  logic [31:0] CSR_PC,
    output logic [31:0] CSR_RD,
    output logic [31:0] CSR_MTVEC,
    output logic [31:0] CSR_MEPC,
    output logic        CSR_MIE,
    output logic        CSR_INT,
    output logic        CSR_PREV_INT
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

    logic [SYNC_STAGES-1:0] sync_reg, sync_next;
    logic                   edge_reg;
    logic                   int_reg, int_next;
    logic                   sticky_reg, sticky_next;
    logic                   mie_reg, mie_next;
    logic                   mpie_reg, mpie_next;
    logic [31:0]            mtvec_reg, mtvec_next;
    logic [31:0]            mepc_reg, mepc_next;
    logic [31:0]            mcause_reg, mcause_next;
    logic [31:0]            rd_value;
    logic [31:0]            wr_value;
    logic                   wr_en;
    logic                   rise;

    // Synchroniser chain: stage 0 samples the raw pin, each later stage the one before.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = CSR_INT_IN;
            end else begin : g_rest
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    assign rise = sync_reg[SYNC_STAGES-1] & ~edge_reg;

    always_comb begin
        rd_value = 32'h0;
        case (CSR_ADDR)
            ADDR_MSTATUS: rd_value = {24'h0, mpie_reg, 3'b000, mie_reg, 3'b000};
            ADDR_MTVEC:   rd_value = mtvec_reg;
            ADDR_MEPC:    rd_value = mepc_reg;
            ADDR_MCAUSE:  rd_value = mcause_reg;
            default:      rd_value = 32'h0;
        endcase
    end

    always_comb begin
        wr_value = rd_value;
        case (CSR_FUNC3[1:0])
            2'b01:   wr_value = CSR_WD;
            2'b10:   wr_value = rd_value | CSR_WD;
            2'b11:   wr_value = rd_value & ~CSR_WD;
            default: wr_value = rd_value;
        endcase
    end

    assign wr_en = CSR_WRITE & (CSR_FUNC3[1:0] != 2'b00);

    always_comb begin
        mie_next    = mie_reg;
        mpie_next   = mpie_reg;
        mtvec_next  = mtvec_reg;
        mepc_next   = mepc_reg;
        mcause_next = mcause_reg;
        int_next    = rise & mie_reg;
        // A pulse the FSM sees in its final cycle is consumed, unless that cycle is INTER.
        if (CSR_INT_CLR) begin
            sticky_next = int_reg & CSR_INT_TAKEN;
        end else begin
            sticky_next = sticky_reg | int_reg;
        end
        if (CSR_INT_TAKEN) begin
            mepc_next   = {CSR_PC[31:2], 2'b00};
            mpie_next   = mie_reg;
            mie_next    = 1'b0;
            mcause_next = MCAUSE_EXT;
        end else if (CSR_MRET) begin
            mie_next  = mpie_reg;
            mpie_next = 1'b1;
        end else if (wr_en) begin
            case (CSR_ADDR)
                ADDR_MSTATUS: begin
                    mie_next  = wr_value[3];
                    mpie_next = wr_value[7];
                end
                ADDR_MTVEC:  mtvec_next  = {wr_value[31:2], 2'b00};
                ADDR_MEPC:   mepc_next   = {wr_value[31:2], 2'b00};
                ADDR_MCAUSE: mcause_next = wr_value;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CSR_CLK or negedge CSR_RESET_N) begin
        if (!CSR_RESET_N) begin
            sync_reg   <= '0;
            edge_reg   <= 1'b0;
            int_reg    <= 1'b0;
            sticky_reg <= 1'b0;
            mie_reg    <= 1'b0;
            mpie_reg   <= 1'b0;
            mtvec_reg  <= MTVEC_RST;
            mepc_reg   <= 32'h0;
            mcause_reg <= 32'h0;
        end else begin
            sync_reg   <= sync_next;
            edge_reg   <= sync_reg[SYNC_STAGES-1];
            int_reg    <= int_next;
            sticky_reg <= sticky_next;
            mie_reg    <= mie_next;
            mpie_reg   <= mpie_next;
            mtvec_reg  <= mtvec_next;
            mepc_reg   <= mepc_next;
            mcause_reg <= mcause_next;
        end
    end

    assign CSR_RD       = rd_value;
    assign CSR_MTVEC    = mtvec_reg;
    assign CSR_MEPC     = mepc_reg;
    assign CSR_MIE      = mie_reg;
    assign CSR_INT      = int_reg;
    assign CSR_PREV_INT = sticky_reg & mie_reg;

endmodule

// File: tb/tb_otter_csr_int.sv
// Directed bench for otter_csr_int: CSR ops, interrupt sync/edge timing, trap entry/MRET,
// sticky pending behaviour and asynchronous reset.
module tb_otter_csr_int;

    localparam logic [31:0] MTVEC_RST = 32'h0000_0040;

    logic        clk;
    logic        rst_n;
    logic        int_in, int_taken, int_clr, csr_write, mret;
    logic [2:0]  func3;
    logic [11:0] addr;
    logic [31:0] wd, pc;
    logic [31:0] rd, mtvec, mepc;
    logic        mie, int_out, prev_int;

    int errs   = 0;
    int checks = 0;

    otter_csr_int #(
        .SYNC_STAGES(2),
        .MTVEC_RST  (MTVEC_RST),
        .MCAUSE_EXT (32'h8000_000B)
    ) dut (
        .CSR_CLK      (clk),
        .CSR_RESET_N  (rst_n),
        .CSR_INT_IN   (int_in),
        .CSR_INT_TAKEN(int_taken),
        .CSR_INT_CLR  (int_clr),
        .CSR_WRITE    (csr_write),
        .CSR_MRET     (mret),
        .CSR_FUNC3    (func3),
        .CSR_ADDR     (addr),
        .CSR_WD       (wd),
        .CSR_PC       (pc),
        .CSR_RD       (rd),
        .CSR_MTVEC    (mtvec),
        .CSR_MEPC     (mepc),
        .CSR_MIE      (mie),
        .CSR_INT      (int_out),
        .CSR_PREV_INT (prev_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; returns on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic read_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, rd, exp);
    endtask

    // One CSR instruction: checks the old value on CSR_RD, then commits on the next edge.
    task automatic csr_op(input string tag, input logic [2:0] f3, input logic [11:0] a,
                          input logic [31:0] d, input logic [31:0] old_exp);
        csr_write = 1'b1;
        func3     = f3;
        addr      = a;
        wd        = d;
        #1;
        $display("csr op %s f3=%0d addr=0x%03h wd=0x%08h rd=0x%08h", tag, f3, a, d, rd);
        chk({tag, "_old"}, rd, old_exp);
        tick();
        csr_write = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; int_in = 1'b0; int_taken = 1'b0; int_clr = 1'b0;
        csr_write = 1'b0; mret = 1'b0; func3 = 3'b000; addr = 12'h000;
        wd = 32'h0; pc = 32'h0;
        @(negedge clk); @(negedge clk);
        chk("rst_mtvec", mtvec, MTVEC_RST);
        chk("rst_mepc", mepc, 32'h0);
        chk("rst_mie", {31'h0, mie}, 32'h0);
        chk("rst_int", {31'h0, int_out}, 32'h0);
        chk("rst_prev", {31'h0, prev_int}, 32'h0);
        read_chk("rst_mstatus", 12'h300, 32'h0);
        rst_n = 1'b1;
        tick();

        // mtvec write: low bits forced to zero
        csr_op("rw_mtvec", 3'b001, 12'h305, 32'h0000_0103, MTVEC_RST);
        chk("mtvec_new", mtvec, 32'h0000_0100);
        read_chk("rd_mtvec", 12'h305, 32'h0000_0100);

        // Enable MIE, then a rising interrupt pulses 3 edges later for one cycle
        csr_op("rs_mie", 3'b010, 12'h300, 32'h0000_0008, 32'h0);
        chk("mie_set", {31'h0, mie}, 32'h1);
        int_in = 1'b1;
        tick(); chk("int_e1", {31'h0, int_out}, 32'h0);
        tick(); chk("int_e2", {31'h0, int_out}, 32'h0);
        tick(); chk("int_e3", {31'h0, int_out}, 32'h1);
        tick(); chk("int_e4", {31'h0, int_out}, 32'h0);
        chk("prev_set", {31'h0, prev_int}, 32'h1);
        tick();
        chk("int_level", {31'h0, int_out}, 32'h0);
        chk("prev_hold", {31'h0, prev_int}, 32'h1);
        int_clr = 1'b1;
        tick();
        int_clr = 1'b0;
        chk("prev_clr", {31'h0, prev_int}, 32'h0);
        int_in = 1'b0;
        repeat (3) tick();

        // Trap entry from a misaligned PC, then MRET with a concurrent write that must lose
        int_taken = 1'b1; int_clr = 1'b1; pc = 32'h0000_0237;
        tick();
        int_taken = 1'b0; int_clr = 1'b0;
        $display("trap entry pc=0x00000237 mepc=0x%08h", mepc);
        chk("trap_mepc", mepc, 32'h0000_0234);
        chk("trap_mie", {31'h0, mie}, 32'h0);
        read_chk("trap_mcause", 12'h342, 32'h8000_000B);
        read_chk("trap_mstatus", 12'h300, 32'h0000_0080);
        mret = 1'b1; csr_write = 1'b1; func3 = 3'b011; addr = 12'h300; wd = 32'h88;
        tick();
        mret = 1'b0; csr_write = 1'b0;
        $display("mret mie=%0d", mie);
        read_chk("mret_mstatus", 12'h300, 32'h0000_0088);
        chk("mret_mepc", mepc, 32'h0000_0234);

        // Pulse coincident with INTER: kept sticky but masked until MRET
        int_in = 1'b1;
        repeat (3) tick();
        chk("int_inter", {31'h0, int_out}, 32'h1);
        int_taken = 1'b1; int_clr = 1'b1; pc = 32'h0000_0300;
        tick();
        int_taken = 1'b0; int_clr = 1'b0;
        chk("inter_prev0", {31'h0, prev_int}, 32'h0);
        chk("inter_mepc", mepc, 32'h0000_0300);
        tick();
        chk("inter_prev1", {31'h0, prev_int}, 32'h0);
        mret = 1'b1;
        tick();
        mret = 1'b0;
        chk("mret_prev", {31'h0, prev_int}, 32'h1);
        int_clr = 1'b1;
        tick();
        int_clr = 1'b0;
        chk("mret_prev_clr", {31'h0, prev_int}, 32'h0);
        int_in = 1'b0;
        repeat (3) tick();

        // Clear both mstatus bits, then a rise with MIE=0 is dropped
        csr_op("rc_mstatus", 3'b011, 12'h300, 32'h0000_0088, 32'h0000_0088);
        read_chk("mstatus_zero", 12'h300, 32'h0);
        int_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("masked_int", {31'h0, int_out}, 32'h0);
        end
        csr_op("rsi_mie", 3'b110, 12'h300, 32'h0000_0008, 32'h0);
        chk("masked_prev", {31'h0, prev_int}, 32'h0);
        tick();
        chk("masked_late", {31'h0, int_out}, 32'h0);
        int_in = 1'b0;

        // Unimplemented address, func3=000, mepc alignment, full-width mcause
        csr_op("rw_7c0", 3'b001, 12'h7C0, 32'hFFFF_FFFF, 32'h0);
        chk("ign_mtvec", mtvec, 32'h0000_0100);
        chk("ign_mepc", mepc, 32'h0000_0300);
        read_chk("ign_mstatus", 12'h300, 32'h0000_0008);
        csr_op("nop_mtvec", 3'b100, 12'h305, 32'h0, 32'h0000_0100);
        chk("nop_mtvec_new", mtvec, 32'h0000_0100);
        csr_op("rs_mepc", 3'b010, 12'h341, 32'h0000_0003, 32'h0000_0300);
        chk("mepc_align", mepc, 32'h0000_0300);
        csr_op("rw_mcause", 3'b001, 12'h342, 32'h1234_5677, 32'h8000_000B);
        read_chk("mcause_full", 12'h342, 32'h1234_5677);
        csr_op("rci_mtvec", 3'b111, 12'h305, 32'h0000_0100, 32'h0000_0100);
        chk("rc_mtvec", mtvec, 32'h0);

        // Asynchronous reset mid-run, checked before any clock edge
        #2 rst_n = 1'b0;
        #1;
        $display("async reset asserted");
        chk("arst_mtvec", mtvec, MTVEC_RST);
        chk("arst_mepc", mepc, 32'h0);
        chk("arst_mie", {31'h0, mie}, 32'h0);
        chk("arst_prev", {31'h0, prev_int}, 32'h0);
        read_chk("arst_mcause", 12'h342, 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
